// File: rtl/score_bcd_accumulator.sv
// Score accumulator: converts each binary increment to BCD (serial double-dabble),
// adds it digit by digit into a work copy of the score, then commits atomically.
module score_bcd_accumulator #(
    parameter int DIGITS      = 4,
    parameter int ADD_W       = 8,
    parameter int CONV_DIGITS = (ADD_W + 2) / 3
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [ADD_W-1:0]      add_points,
    output logic                  add_ready,
    output logic [DIGITS*4-1:0]   digits,
    output logic                  busy,
    output logic                  overflow
);

    localparam int CNT_W   = $clog2((ADD_W > DIGITS ? ADD_W : DIGITS) + 1);
    localparam int CONV_W  = CONV_DIGITS * 4;
    localparam int SCORE_W = DIGITS * 4;
    localparam logic [CNT_W-1:0]   CONV_LAST = CNT_W'(ADD_W - 1);
    localparam logic [CNT_W-1:0]   ADD_LAST  = CNT_W'(DIGITS - 1);
    localparam logic [SCORE_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, CONV, ADD, COMMIT} state_t;

    state_t               state;
    state_t               state_next;
    logic [ADD_W-1:0]     bin_q;
    logic [CONV_W-1:0]    conv_q;
    logic [SCORE_W-1:0]   work_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 carry_q;
    logic [SCORE_W-1:0]   digits_q;
    logic                 overflow_q;

    logic                      accept;
    logic [CONV_W-1:0]         conv_adj;
    logic [CONV_W+ADD_W-1:0]   dd_shift;
    logic [3:0]                conv_digit;
    logic [4:0]                digit_sum;
    logic [3:0]                sum_digit;
    logic                      sum_carry;
    logic [SCORE_W+3:0]        work_rot;
    logic                      conv_high_nz;

    // Handshake: an increment transfers on a rising edge where add_valid and add_ready
    // are both high; add_ready is only offered in IDLE and never during a clear cycle.
    assign add_ready = (state == IDLE) && !clear;
    assign accept    = add_valid && add_ready;
    assign busy      = (state != IDLE);
    assign digits    = digits_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (cnt_q == CONV_LAST) state_next = ADD;
            ADD:     if (cnt_q == ADD_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    // Double-dabble step: bias nibbles >= 5 by 3, then shift {bcd, bin} left once.
    always_comb begin
        conv_adj = conv_q;
        for (int i = 0; i < CONV_DIGITS; i++) begin
            if (conv_q[i*4 +: 4] >= 4'd5) conv_adj[i*4 +: 4] = conv_q[i*4 +: 4] + 4'd3;
        end
        dd_shift = {conv_adj, bin_q} << 1;
    end

    // The work score rotates right one nibble per ADD cycle, so the digit being
    // summed is always in the bottom nibble and the order is restored after DIGITS steps.
    always_comb begin
        conv_digit = 4'd0;
        for (int i = 0; i < CONV_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) conv_digit = conv_q[i*4 +: 4];
        end
        digit_sum = {1'b0, work_q[3:0]} + {1'b0, conv_digit} + {4'd0, carry_q};
        if (digit_sum > 5'd9) begin
            sum_digit = 4'(digit_sum - 5'd10);
            sum_carry = 1'b1;
        end else begin
            sum_digit = digit_sum[3:0];
            sum_carry = 1'b0;
        end
        work_rot = {sum_digit, work_q};
    end

    always_comb begin
        conv_high_nz = 1'b0;
        for (int i = 0; i < CONV_DIGITS; i++) begin
            if (i >= DIGITS && conv_q[i*4 +: 4] != 4'd0) conv_high_nz = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bin_q      <= '0;
            conv_q     <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bin_q   <= add_points;
                        conv_q  <= '0;
                        work_q  <= digits_q;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                CONV: begin
                    conv_q <= dd_shift[CONV_W+ADD_W-1:ADD_W];
                    bin_q  <= dd_shift[ADD_W-1:0];
                    cnt_q  <= (cnt_q == CONV_LAST) ? '0 : cnt_q + 1'b1;
                end
                ADD: begin
                    work_q  <= work_rot[SCORE_W+3:4];
                    carry_q <= sum_carry;
                    cnt_q   <= (cnt_q == ADD_LAST) ? '0 : cnt_q + 1'b1;
                end
                COMMIT: begin
                    if (carry_q || conv_high_nz) begin
                        digits_q   <= ALL_NINES;
                        overflow_q <= 1'b1;
                    end else begin
                        digits_q <= work_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Bench for score_bcd_accumulator: integer score model checked every cycle on a
// 4-digit instance, plus directed literal checks on 4-digit and 2-digit instances.
module tb_score_bcd_accumulator;

    localparam int ADD_W    = 8;
    localparam int DIGITS_A = 4;
    localparam int DIGITS_B = 2;
    localparam int LAT_A    = ADD_W + DIGITS_A + 1;
    localparam int LAT_B    = ADD_W + DIGITS_B + 1;
    localparam int MAX_A    = 9999;

    logic                    clk = 1'b0;
    logic                    resetN;
    logic                    clear;
    logic                    valid_a, valid_b;
    logic [ADD_W-1:0]        points_a, points_b;
    logic                    ready_a, ready_b;
    logic [DIGITS_A*4-1:0]   digits_a;
    logic [DIGITS_B*4-1:0]   digits_b;
    logic                    busy_a, busy_b;
    logic                    ovf_a, ovf_b;

    int   checks   = 0;
    int   failures = 0;
    logic cmp_en   = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    score_bcd_accumulator #(.DIGITS(DIGITS_A), .ADD_W(ADD_W)) u_dut_a (
        .clk(clk), .resetN(resetN), .clear(clear),
        .add_valid(valid_a), .add_points(points_a), .add_ready(ready_a),
        .digits(digits_a), .busy(busy_a), .overflow(ovf_a)
    );

    score_bcd_accumulator #(.DIGITS(DIGITS_B), .ADD_W(ADD_W)) u_dut_b (
        .clk(clk), .resetN(resetN), .clear(clear),
        .add_valid(valid_b), .add_points(points_b), .add_ready(ready_b),
        .digits(digits_b), .busy(busy_b), .overflow(ovf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (DIGITS_A instance) ----------------
    int   m_score;
    logic m_ovf;
    int   m_left;
    int   m_pend;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_score <= 0;
            m_ovf   <= 1'b0;
            m_left  <= 0;
            m_pend  <= 0;
        end else if (clear) begin
            m_score <= 0;
            m_ovf   <= 1'b0;
            m_left  <= 0;
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
        end else if (m_left == 1) begin
            m_left <= 0;
            if (m_score + m_pend > MAX_A) begin
                m_score <= MAX_A;
                m_ovf   <= 1'b1;
            end else begin
                m_score <= m_score + m_pend;
            end
        end else if (valid_a) begin
            m_pend <= int'(points_a);
            m_left <= LAT_A;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("cyc_digits",    32'(digits_a), 32'(to_bcd(m_score)));
            check("cyc_busy",      32'(busy_a),   32'(m_left > 0));
            check("cyc_add_ready", 32'(ready_a),  32'((m_left == 0) && !clear));
            check("cyc_overflow",  32'(ovf_a),    32'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_add(input bit sel, input logic [ADD_W-1:0] pts);
        int n;
        @(negedge clk);
        if (sel) begin valid_b = 1'b1; points_b = pts; end
        else     begin valid_a = 1'b1; points_a = pts; end
        #1;
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_wait", 32'(n >= 40), 32'd0);
        @(posedge clk);
        #1;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        points_a = ADD_W'($urandom_range(0, 255));
        points_b = ADD_W'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? ready_b : ready_a) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_add(input bit sel, input logic [ADD_W-1:0] pts);
        int lat;
        start_add(sel, pts);
        wait_done(sel, lat);
        check("latency", 32'(lat), sel ? 32'(LAT_B) : 32'(LAT_A));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        resetN = 1'b0; clear = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        points_a = '0; points_b = '0;
        #12;
        check("rst_digits", 32'(digits_a), 32'h0);
        check("rst_busy",   32'(busy_a),   32'h0);
        check("rst_ovf",    32'(ovf_a),    32'h0);
        @(negedge clk);
        resetN = 1'b1;
        cmp_en = 1'b1;
        #1;
        check("rst_ready", 32'(ready_a), 32'h1);

        do_add(0, 8'd25);
        check("add25_digits", 32'(digits_a), 32'h0025);
        check("add25_ovf",    32'(ovf_a),    32'h0);

        pulse_clear();
        do_add(0, 8'd255);
        do_add(0, 8'd255);
        do_add(0, 8'd90);
        check("b2b_digits", 32'(digits_a), 32'h0600);

        pulse_clear();
        for (int i = 0; i < 39; i++) do_add(0, 8'd255);
        do_add(0, 8'd45);
        check("pre_digits", 32'(digits_a), 32'h9990);
        check("pre_ovf",    32'(ovf_a),    32'h0);
        do_add(0, 8'd20);
        check("sat_digits", 32'(digits_a), 32'h9999);
        check("sat_ovf",    32'(ovf_a),    32'h1);
        do_add(0, 8'd1);
        check("sat1_digits", 32'(digits_a), 32'h9999);
        check("sat1_ovf",    32'(ovf_a),    32'h1);
        do_add(0, 8'd0);
        check("sat0_digits", 32'(digits_a), 32'h9999);

        pulse_clear();
        check("clr_digits", 32'(digits_a), 32'h0);
        check("clr_ovf",    32'(ovf_a),    32'h0);
        do_add(0, 8'd42);
        check("add42_digits", 32'(digits_a), 32'h0042);
        start_add(0, 8'd7);
        repeat (3) @(posedge clk);
        pulse_clear();
        repeat (20) @(posedge clk);
        #1;
        check("abort_digits", 32'(digits_a), 32'h0);
        check("abort_busy",   32'(busy_a),   32'h0);
        do_add(0, 8'd3);
        check("add3_digits", 32'(digits_a), 32'h0003);
        do_add(0, 8'd0);
        check("add0_digits", 32'(digits_a), 32'h0003);

        @(negedge clk);
        clear = 1'b1; valid_a = 1'b1; points_a = 8'd9;
        repeat (3) begin
            #1;
            check("clrv_ready", 32'(ready_a), 32'h0);
            @(posedge clk);
            #1;
            check("clrv_busy", 32'(busy_a), 32'h0);
            @(negedge clk);
        end
        clear = 1'b0; valid_a = 1'b0;
        #1;
        check("clrv_digits", 32'(digits_a), 32'h0);

        do_add(0, 8'd5);
        check("add5_digits", 32'(digits_a), 32'h0005);
        start_add(0, 8'd7);
        repeat (10) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("arst_digits", 32'(digits_a), 32'h0);
        check("arst_busy",   32'(busy_a),   32'h0);
        check("arst_ovf",    32'(ovf_a),    32'h0);
        @(negedge clk);
        resetN = 1'b1;
        do_add(0, 8'd3);
        check("post_rst_digits", 32'(digits_a), 32'h0003);

        check("b_rst_digits", 32'(digits_b), 32'h0);
        do_add(1, 8'd42);
        do_add(1, 8'd57);
        check("b99_digits", 32'(digits_b), 32'h99);
        check("b99_ovf",    32'(ovf_b),    32'h0);
        pulse_clear();
        do_add(1, 8'd150);
        check("b150_digits", 32'(digits_b), 32'h99);
        check("b150_ovf",    32'(ovf_b),    32'h1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_accumulator.md
Name: score_bcd_accumulator

Overview:
- Producer end of the score-display path: accumulates game points and presents them as packed BCD digits, one 4-bit nibble per digit.
- The digit bus plugs directly into the `digits` input of the on-screen score renderer.
- Point increments arrive as binary values over a valid/ready handshake from game logic (asteroid hits, bonuses).
- Each increment goes through a serial double-dabble conversion and a serial BCD add. The displayed value updates atomically, once per increment.

Parameters:
- DIGITS, 4, number of displayed BCD digits; 1..8.
- ADD_W, 8, width of the binary point increment.
- CONV_DIGITS, (ADD_W+2)/3, BCD digits produced by the converter; internal, not to be overridden.

Ports:
- clk  in  1  system clock (pixel clock domain).
- resetN  in  1  asynchronous active-low reset.
- clear  in  1  synchronous score clear (new game).
- add_valid  in  1  increment request.
- add_points  in  ADD_W  binary increment; 0 is legal.
- add_ready  out  1  block can accept an increment.
- digits  out  DIGITS*4  packed BCD score; nibble 0 (bits 3:0) is the least significant digit.
- busy  out  1  an increment is in progress.
- overflow  out  1  sticky; score saturated.

Behaviour:
- Reset (resetN low, asynchronous): state IDLE, digits=0, overflow=0, busy=0, all work registers 0.
- add_ready = (state==IDLE) && !clear. busy = (state!=IDLE).
- Handshake: an increment is accepted on a rising edge where add_valid && add_ready. add_points is captured on that edge and may change afterwards.
- States:
  - IDLE: on accept, load shift register = add_points, BCD register = 0, counter = 0, go to CONV.
  - CONV: one double-dabble step per cycle. Any BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1. Runs ADD_W cycles, then go to ADD.
  - ADD: one digit per cycle, LSD first: sum = score_work[i] + conv[i] + carry. If sum >9, subtract 10 and set carry. Conv digits at index >= CONV_DIGITS are 0. Runs DIGITS cycles, then go to COMMIT.
  - COMMIT: if final carry=1, or any conv digit at index >= DIGITS is nonzero, set digits to all 9s and set overflow. Otherwise digits=score_work. Go to IDLE.
- score_work is loaded from digits on accept. digits never shows a partial result.
- Latency: digits updates at edge ADD_W+DIGITS+1 after the accept edge (default 13 cycles). add_ready reasserts in the same cycle that digits updates.
- Saturation: while overflow=1, increments are still accepted and complete normally. digits stays all 9s.
- clear: highest priority, synchronous. In any state it forces IDLE, digits=0, overflow=0 and aborts an in-flight increment with no commit. add_ready is low during the clear cycle, so an add_valid concurrent with clear is not accepted.
- add_points=0 runs the full sequence and leaves digits unchanged.
- Reset mid-operation: immediate return to the reset values. The pending increment is lost.
- Back-to-back: the earliest next accept is the cycle after COMMIT. Throughput is one increment per ADD_W+DIGITS+2 cycles.

Test Plan:
- Reset, then add 25 -> add_ready low for 13 cycles, digits=16'h0025, overflow=0.
- Add 255, then 255, then 90 -> digits=16'h0600 after the third commit. Checks carry across three nibbles and back-to-back accepts.
- Preload 9990 via repeated adds, then add 20 -> digits=16'h9999, overflow=1. A further add of 1 keeps digits=16'h9999.
- DIGITS=2, ADD_W=8: add 150 -> conversion digit 2 is nonzero, so digits=8'h99 and overflow=1.
- Assert clear during the CONV cycle of an add of 7 with score 0042 -> digits=0, no later commit of 7. The next add of 3 gives 0003.
- Hold add_valid high with clear high for 3 cycles -> nothing accepted, add_ready=0. Drop resetN mid-ADD -> digits=0 and busy=0 immediately, before the next clock edge.
